// File: rtl/tape_buff_arb.sv
// Single-port buffer RAM sequencer: round-robin read windows for two byte
// readers, with a one-deep holding register for download writes.
module tape_buff_arb #(
    parameter int AW  = 25,
    parameter int WIN = 2,
    parameter int TMO = 64
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    output logic          rd_en0,
    output logic          rd_en1,
    input  logic          rd0,
    input  logic          rd1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    output logic [7:0]    din0,
    output logic [7:0]    din1,
    input  logic          wr,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    output logic          wr_busy,
    output logic          mem_rd,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_dout,
    input  logic          mem_ready,
    output logic          err
);
    localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int TW = $clog2(TMO + 1);
    localparam logic [WW-1:0] WCNT_INIT = WW'(WIN - 1);
    localparam logic [TW-1:0] TCNT_INIT = TW'(TMO);

    typedef enum logic [2:0] {S_IDLE, S_OPEN, S_RD, S_WR, S_GAP} state_t;

    state_t        state_reg, state_next;
    logic          ptr_reg, ptr_next;
    logic [WW-1:0] wcnt_reg, wcnt_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic [1:0]    rd_en_reg, rd_en_next;
    logic          mem_rd_reg, mem_rd_next;
    logic          mem_we_reg, mem_we_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [7:0]    mem_wdata_reg, mem_wdata_next;
    logic          err_reg, err_next;
    logic          hold_valid_reg, hold_valid_next;
    logic [AW-1:0] hold_addr_reg, hold_addr_next;
    logic [7:0]    hold_data_reg, hold_data_next;

    logic [1:0]    rd_req;
    logic [AW-1:0] rd_addr [2];
    logic          req_hit;
    logic          timed_out;
    logic          access_done;
    logic          rd_done;
    logic          wr_done;
    logic [7:0]    rd_data;

    assign rd_req     = {rd1, rd0};
    assign rd_addr[0] = addr0;
    assign rd_addr[1] = addr1;
    assign req_hit    = rd_req[ptr_reg];

    // A timeout completes the access exactly as a mem_ready would, with 8'hFF as read data
    assign timed_out   = !mem_ready && (tcnt_reg == '0);
    assign access_done = mem_ready || timed_out;
    assign rd_done     = (state_reg == S_RD) && access_done;
    assign wr_done     = (state_reg == S_WR) && access_done;
    assign rd_data     = mem_ready ? mem_dout : 8'hFF;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: state_next = hold_valid_reg ? S_WR : S_OPEN;
            S_OPEN: begin
                if (req_hit) begin
                    state_next = S_RD;
                end else if (wcnt_reg == '0) begin
                    state_next = S_IDLE;
                end
            end
            S_RD, S_WR: begin
                if (access_done) begin
                    state_next = S_GAP;
                end
            end
            S_GAP:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_next       = ptr_reg;
        wcnt_next      = wcnt_reg;
        tcnt_next      = tcnt_reg;
        rd_en_next     = rd_en_reg;
        mem_rd_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        err_next       = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (hold_valid_reg) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = hold_addr_reg;
                    mem_wdata_next = hold_data_reg;
                    tcnt_next      = TCNT_INIT;
                end else begin
                    rd_en_next[ptr_reg] = 1'b1;
                    wcnt_next           = WCNT_INIT;
                end
            end
            S_OPEN: begin
                if (req_hit) begin
                    mem_rd_next   = 1'b1;
                    mem_addr_next = rd_addr[ptr_reg];
                    tcnt_next     = TCNT_INIT;
                end else if (wcnt_reg == '0) begin
                    rd_en_next[ptr_reg] = 1'b0;
                    ptr_next            = ~ptr_reg;
                end else begin
                    wcnt_next = wcnt_reg - WW'(1);
                end
            end
            S_RD: begin
                if (access_done) begin
                    rd_en_next[ptr_reg] = 1'b0;
                    ptr_next            = ~ptr_reg;
                    err_next            = err_reg | timed_out;
                end else begin
                    tcnt_next = tcnt_reg - TW'(1);
                end
            end
            S_WR: begin
                if (access_done) begin
                    err_next = err_reg | timed_out;
                end else begin
                    tcnt_next = tcnt_reg - TW'(1);
                end
            end
            default: ;
        endcase
    end

    // The holding register may be refilled on the very edge it is released
    always_comb begin
        hold_valid_next = hold_valid_reg && !wr_done;
        hold_addr_next  = hold_addr_reg;
        hold_data_next  = hold_data_reg;
        if (wr && !hold_valid_next) begin
            hold_valid_next = 1'b1;
            hold_addr_next  = waddr;
            hold_data_next  = wdata;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg        <= 1'b0;
            wcnt_reg       <= '0;
            tcnt_reg       <= '0;
            rd_en_reg      <= '0;
            mem_rd_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            err_reg        <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_addr_reg  <= '0;
            hold_data_reg  <= '0;
        end else begin
            ptr_reg        <= ptr_next;
            wcnt_reg       <= wcnt_next;
            tcnt_reg       <= tcnt_next;
            rd_en_reg      <= rd_en_next;
            mem_rd_reg     <= mem_rd_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            err_reg        <= err_next;
            hold_valid_reg <= hold_valid_next;
            hold_addr_reg  <= hold_addr_next;
            hold_data_reg  <= hold_data_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_din
            logic [7:0] din_reg;
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    din_reg <= '0;
                end else if (rd_done && (ptr_reg == 1'(gi))) begin
                    din_reg <= rd_data;
                end
            end
        end
    endgenerate

    assign rd_en0    = rd_en_reg[0];
    assign rd_en1    = rd_en_reg[1];
    assign din0      = g_din[0].din_reg;
    assign din1      = g_din[1].din_reg;
    assign wr_busy   = hold_valid_reg;
    assign mem_rd    = mem_rd_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign err       = err_reg;
endmodule
